// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the blocks that feed the aes encryption core.
//   AES_BLK_W      : width of one AES block and of the key (128 bits)
//   AES_WORD_W     : width of one plaintext word on the stream input (32 bits)
//   packer_state_e : states of the aes_in_packer controller
// -----------------------------------------------------------------------------
package aes_pkg;

  localparam int AES_BLK_W  = 128;
  localparam int AES_WORD_W = 32;

  typedef enum logic [1:0] {
    PK_FILL  = 2'd0,
    PK_ISSUE = 2'd1,
    PK_WAIT  = 2'd2
  } packer_state_e;

endpackage : aes_pkg

// File: rtl/aes_in_packer.sv
// -----------------------------------------------------------------------------
// aes_in_packer
// Packs four 32-bit plaintext words into one 128-bit block, holds a separately
// loaded key and issues one block at a time to the aes core. The core has no
// backpressure, so after each issue the packer waits for the core's result
// strobe (or a timeout) before collecting the next block.
//
// Parameters
//   TIMEOUT : maximum cycles spent in WAIT before giving up (>= 2)
//   CNT_W   : width of the issued-block counter
// Ports
//   clk, resetn     : clock (rising edge) and synchronous active-low reset
//   s_valid/s_ready : plaintext word handshake, s_data is the word
//                     (the first word of a block ends up in bits [127:96])
//   key_load        : key strobe, effective only while key_ready is high
//   key_value       : key to load
//   key_ready       : high while collecting words (key may be changed)
//   flush           : discard partially collected words
//   aes_data_valid  : one-cycle issue pulse to the core
//   aes_data        : block to the core
//   aes_key         : key to the core
//   aes_res_valid   : result strobe from the core
//   busy            : a block is being issued or is in flight
//   err_timeout     : sticky, the core failed to answer within TIMEOUT cycles
//   blk_cnt         : number of blocks issued, wraps to 0
// -----------------------------------------------------------------------------
module aes_in_packer
  import aes_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [AES_WORD_W-1:0] s_data,
  input  logic                  key_load,
  input  logic [AES_BLK_W-1:0]  key_value,
  output logic                  key_ready,
  input  logic                  flush,
  output logic                  aes_data_valid,
  output logic [AES_BLK_W-1:0]  aes_data,
  output logic [AES_BLK_W-1:0]  aes_key,
  input  logic                  aes_res_valid,
  output logic                  busy,
  output logic                  err_timeout,
  output logic [CNT_W-1:0]      blk_cnt
);

  localparam int TCNT_W = $clog2(TIMEOUT);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  packer_state_e        state_q,   state_d;
  logic [1:0]           wcnt_q,    wcnt_d;
  logic [AES_BLK_W-1:0] data_q,    data_d;
  logic [AES_BLK_W-1:0] key_q,     key_d;
  logic                 key_vld_q, key_vld_d;
  logic [TCNT_W-1:0]    tcnt_q,    tcnt_d;
  logic                 err_q,     err_d;
  logic [CNT_W-1:0]     blk_cnt_q, blk_cnt_d;

  logic accept;

  // Handshake outputs depend only on registered state and flush, never on
  // s_valid, so an upstream that waits for s_ready cannot form a loop.
  assign key_ready      = (state_q == PK_FILL);
  assign s_ready        = (state_q == PK_FILL) && key_vld_q && !flush;
  assign accept         = s_valid && s_ready;
  assign busy           = (state_q == PK_ISSUE) || (state_q == PK_WAIT);
  assign aes_data_valid = (state_q == PK_ISSUE);
  assign aes_data       = data_q;
  assign aes_key        = key_q;
  assign err_timeout    = err_q;
  assign blk_cnt        = blk_cnt_q;

  always_comb begin
    // NOTE: every _d gets its hold value first; a path that forgets to assign
    // one would otherwise infer a latch instead of a held flop.
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    data_d    = data_q;
    key_d     = key_q;
    key_vld_d = key_vld_q;
    tcnt_d    = tcnt_q;
    err_d     = err_q;
    blk_cnt_d = blk_cnt_q;

    unique case (state_q)
      PK_FILL: begin
        // Loading alongside the fourth word is fine: the key register is
        // written on the same edge that moves to ISSUE, so that block uses it.
        if (key_load) begin
          key_d     = key_value;
          key_vld_d = 1'b1;
        end
        if (flush) begin
          wcnt_d = '0;
          data_d = '0;
        end else if (accept) begin
          data_d = {data_q[AES_BLK_W-AES_WORD_W-1:0], s_data};
          wcnt_d = wcnt_q + 2'd1;
          if (wcnt_q == 2'd3) begin
            state_d = PK_ISSUE;
          end
        end
      end

      PK_ISSUE: begin
        blk_cnt_d = blk_cnt_q + CNT_W'(1);
        tcnt_d    = '0;
        state_d   = PK_WAIT;
      end

      PK_WAIT: begin
        // A response on the final timeout cycle wins over the timeout.
        if (aes_res_valid) begin
          state_d = PK_FILL;
        end else if (tcnt_q == TCNT_LAST) begin
          err_d   = 1'b1;
          state_d = PK_FILL;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end

      default: state_d = PK_FILL;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= PK_FILL;
      wcnt_q    <= '0;
      data_q    <= '0;
      key_q     <= '0;
      key_vld_q <= 1'b0;
      tcnt_q    <= '0;
      err_q     <= 1'b0;
      blk_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      data_q    <= data_d;
      key_q     <= key_d;
      key_vld_q <= key_vld_d;
      tcnt_q    <= tcnt_d;
      err_q     <= err_d;
      blk_cnt_q <= blk_cnt_d;
    end
  end

endmodule : aes_in_packer

// File: tb/tb_aes_in_packer.sv
// -----------------------------------------------------------------------------
// tb_aes_in_packer
// Directed sequence with randomized data against a transaction-level model:
// accepted words are queued, a block is the first four queued words, the key
// is whatever was last loaded while collecting, and the block count is kept
// as an integer modulo 2**CNT_W.
// -----------------------------------------------------------------------------
module tb_aes_in_packer;

  localparam int TIMEOUT = 24;
  localparam int CNT_W   = 2;

  logic         clk;
  logic         resetn;
  logic         s_valid;
  logic         s_ready;
  logic [31:0]  s_data;
  logic         key_load;
  logic [127:0] key_value;
  logic         key_ready;
  logic         flush;
  logic         aes_data_valid;
  logic [127:0] aes_data;
  logic [127:0] aes_key;
  logic         aes_res_valid;
  logic         busy;
  logic         err_timeout;
  logic [CNT_W-1:0] blk_cnt;

  aes_in_packer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .key_load       (key_load),
    .key_value      (key_value),
    .key_ready      (key_ready),
    .flush          (flush),
    .aes_data_valid (aes_data_valid),
    .aes_data       (aes_data),
    .aes_key        (aes_key),
    .aes_res_valid  (aes_res_valid),
    .busy           (busy),
    .err_timeout    (err_timeout),
    .blk_cnt        (blk_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0]  wq[$];
  logic [127:0] key_exp;
  logic [127:0] blk_exp_data;
  int           blk_exp;
  logic         err_exp;

  int n_pass  = 0;
  int n_total = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    #1;
    wq.delete();
    key_exp = '0;
    blk_exp = 0;
    err_exp = 1'b0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_s_ready"},   128'(s_ready),        128'(0));
    chk({tag, "_key_ready"}, 128'(key_ready),      128'(1));
    chk({tag, "_dv"},        128'(aes_data_valid), 128'(0));
    chk({tag, "_data"},      aes_data,             128'(0));
    chk({tag, "_key"},       aes_key,              128'(0));
    chk({tag, "_busy"},      128'(busy),           128'(0));
    chk({tag, "_err"},       128'(err_timeout),    128'(0));
    chk({tag, "_blk_cnt"},   128'(blk_cnt),        128'(0));
  endtask

  task automatic load_key(input logic [127:0] k);
    key_load  = 1'b1;
    key_value = k;
    tick();
    key_load  = 1'b0;
    key_exp   = k;
    #1;
    chk("key_loaded", aes_key, key_exp);
    chk("key_s_ready", 128'(s_ready), 128'(1));
  endtask

  // Present one word while collecting; the model expects it to be accepted.
  task automatic push_word(input logic [31:0] w);
    s_valid = 1'b1;
    s_data  = w;
    #1;
    chk("word_s_ready", 128'(s_ready), 128'(1));
    wq.push_back(w);
    tick();
    s_valid = 1'b0;
  endtask

  // Called in the ISSUE cycle; leaves the bench in the first WAIT cycle.
  task automatic check_issue(input bit res_in_issue);
    blk_exp_data = {wq[0], wq[1], wq[2], wq[3]};
    repeat (4) void'(wq.pop_front());
    chk("issue_dv",      128'(aes_data_valid), 128'(1));
    chk("issue_data",    aes_data,             blk_exp_data);
    chk("issue_key",     aes_key,              key_exp);
    chk("issue_busy",    128'(busy),           128'(1));
    chk("issue_s_ready", 128'(s_ready),        128'(0));
    aes_res_valid = res_in_issue;
    tick();
    aes_res_valid = 1'b0;
    blk_exp = (blk_exp + 1) % (1 << CNT_W);
    #1;
    chk("wait_dv",      128'(aes_data_valid), 128'(0));
    chk("wait_busy",    128'(busy),           128'(1));
    chk("wait_blk_cnt", 128'(blk_cnt),        128'(blk_exp));
  endtask

  task automatic send_block(input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3);
    push_word(w0);
    push_word(w1);
    push_word(w2);
    push_word(w3);
    check_issue(1'b0);
  endtask

  // Core answers on the lat-th WAIT cycle (lat <= TIMEOUT). With hammer set,
  // the source keeps offering words and keys that must all be ignored.
  task automatic wait_resp(input int lat, input bit hammer);
    for (int i = 1; i <= lat; i++) begin
      if (hammer) begin
        s_valid   = 1'b1;
        s_data    = $urandom;
        key_load  = 1'b1;
        key_value = {$urandom, $urandom, $urandom, $urandom};
      end
      aes_res_valid = (i == lat);
      #1;
      chk("resp_busy",    128'(busy),        128'(1));
      chk("resp_s_ready", 128'(s_ready),     128'(0));
      chk("resp_key",     aes_key,           key_exp);
      chk("resp_data",    aes_data,          blk_exp_data);
      chk("resp_err",     128'(err_timeout), 128'(err_exp));
      tick();
    end
    aes_res_valid = 1'b0;
    key_load      = 1'b0;
    s_valid       = 1'b0;
    #1;
    chk("after_resp_busy",    128'(busy),        128'(0));
    chk("after_resp_s_ready", 128'(s_ready),     128'(1));
    chk("after_resp_key",     aes_key,           key_exp);
    chk("after_resp_err",     128'(err_timeout), 128'(err_exp));
  endtask

  task automatic wait_timeout();
    for (int i = 1; i <= TIMEOUT; i++) begin
      chk("to_busy", 128'(busy),        128'(1));
      chk("to_err",  128'(err_timeout), 128'(err_exp));
      tick();
    end
    err_exp = 1'b1;
    chk("to_done_busy",    128'(busy),        128'(0));
    chk("to_done_err",     128'(err_timeout), 128'(err_exp));
    chk("to_done_s_ready", 128'(s_ready),     128'(1));
  endtask

  function automatic logic [31:0] rw();
    return $urandom;
  endfunction

  initial begin
    logic [127:0] new_key;
    resetn        = 1'b0;
    s_valid       = 1'b0;
    s_data        = '0;
    key_load      = 1'b0;
    key_value     = '0;
    flush         = 1'b0;
    aes_res_valid = 1'b0;

    // Reset state
    do_reset();
    chk_reset_values("rst");

    // Words offered before any key: never accepted, nothing issued
    s_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_data = rw();
      #1;
      chk("nokey_s_ready", 128'(s_ready),        128'(0));
      chk("nokey_dv",      128'(aes_data_valid), 128'(0));
      tick();
    end
    load_key(128'h5468617473206d79204b756e67204675);
    s_valid = 1'b0;

    // Known-answer block
    send_block(32'h54776f20, 32'h4f6e6520, 32'h4e696e65, 32'h2054776f);
    chk("kat_data", blk_exp_data, 128'h54776f204f6e65204e696e652054776f);
    chk("kat_blk_cnt", 128'(blk_cnt), 128'(1));
    wait_resp(3, 1'b0);

    // Backpressure: 20-cycle core latency with the source pushing throughout
    send_block(rw(), rw(), rw(), rw());
    wait_resp(20, 1'b1);

    // Response coincides with the last timeout cycle: counts as a response
    send_block(rw(), rw(), rw(), rw());
    wait_resp(TIMEOUT, 1'b0);

    // Core never answers
    send_block(rw(), rw(), rw(), rw());
    wait_timeout();

    // Next block still issues, error stays sticky; count wraps after 5 blocks
    send_block(rw(), rw(), rw(), rw());
    chk("wrap_blk_cnt", 128'(blk_cnt), 128'(1));
    wait_resp(5, 1'b0);

    // Flush after two words; a response strobe in FILL and in ISSUE is
    // ignored; a key loaded with the fourth word is used for that block.
    aes_res_valid = 1'b1;
    push_word(rw());
    aes_res_valid = 1'b0;
    push_word(rw());
    s_valid = 1'b1;
    s_data  = rw();
    flush   = 1'b1;
    #1;
    chk("flush_s_ready", 128'(s_ready), 128'(0));
    tick();
    flush   = 1'b0;
    s_valid = 1'b0;
    wq.delete();
    push_word(rw());
    push_word(rw());
    push_word(rw());
    new_key   = {$urandom, $urandom, $urandom, $urandom};
    key_load  = 1'b1;
    key_value = new_key;
    key_exp   = new_key;
    push_word(rw());
    key_load  = 1'b0;
    check_issue(1'b1);
    wait_resp(4, 1'b0);

    // Reset in the middle of WAIT
    send_block(rw(), rw(), rw(), rw());
    tick();
    tick();
    do_reset();
    chk_reset_values("midrst");
    s_valid = 1'b1;
    s_data  = rw();
    tick();
    chk("midrst_nokey_s_ready", 128'(s_ready), 128'(0));
    s_valid = 1'b0;
    load_key({$urandom, $urandom, $urandom, $urandom});
    send_block(rw(), rw(), rw(), rw());
    wait_resp(2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule : tb_aes_in_packer
